// File: rtl/execute_unit.sv
// pine16 execute stage: latches one decoded micro-op per handshake and runs ALU moves or a MAR/MDR memory access.
// Optional {N,C,Z} flag output and logic are built only when EXEC_FLAGS_EN is defined.
module execute_unit #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int AW   = 20,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rqx,
  output logic          byx,
  input  logic [15:0]   opout,
  input  logic [RW-1:0] regsrc,
  input  logic [RW-1:0] regdst,
  input  logic [3:0]    aluop,
  input  logic [DW-1:0] opimm,
  output logic          rqm,
  output logic          rwm,
  input  logic          akm,
  input  logic [DW-1:0] drm,
  output logic [DW-1:0] dwm,
  output logic [AW-1:0] adm
`ifdef EXEC_FLAGS_EN
  ,
  output logic [2:0]    flags
`endif
);

  // Handshake: the decoder holds rqx high with a valid micro-op; it is taken on the
  // first negedge with byx low, and byx stays high until the micro-op retires.
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MREQ, S_NOP} state_e;

  localparam int MW = (AW < DW) ? AW : DW;

  state_e          state_q, state_d;
  logic [1:0]      sel_q, dst_q;
  logic            wen_q, rdir_q;
  logic [3:0]      aop_q;
  logic [RW-1:0]   rs_q, rd_q;
  logic [DW-1:0]   imm_q;
  logic [DW-1:0]   mar_q, mar_d, mdr_q, mdr_d;
  logic [DW-1:0]   regs_q [NREG];

  logic            accept;
  logic            reg_we;
  logic [RW-1:0]   reg_wa;
  logic [DW-1:0]   a_op, b_op, alu_r;
  logic            alu_c;
  logic [DW:0]     sum;

  always_comb begin
    case (sel_q)
      2'b00:   a_op = imm_q;
      2'b01:   a_op = mdr_q;
      2'b10:   a_op = regs_q[rs_q];
      default: a_op = regs_q[rd_q];
    endcase
  end

  assign b_op = regs_q[rd_q];

  always_comb begin
    alu_r = a_op;
    alu_c = 1'b0;
    sum   = '0;
    case (aop_q)
      4'd1: begin
        sum   = {1'b0, a_op} + {1'b0, b_op};
        alu_r = sum[DW-1:0];
        alu_c = sum[DW];
      end
      4'd2: begin
        // b - a as b + ~a + 1 so the carry out reads directly as "no borrow"
        sum   = {1'b0, b_op} + {1'b0, ~a_op} + {{DW{1'b0}}, 1'b1};
        alu_r = sum[DW-1:0];
        alu_c = sum[DW];
      end
      4'd3: alu_r = a_op & b_op;
      4'd4: alu_r = a_op | b_op;
      4'd5: alu_r = a_op ^ b_op;
      4'd6: alu_r = ~a_op;
      4'd7: begin
        alu_r = {a_op[DW-2:0], 1'b0};
        alu_c = a_op[DW-1];
      end
      4'd8: begin
        alu_r = {1'b0, a_op[DW-1:1]};
        alu_c = a_op[0];
      end
      default: alu_r = a_op;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    reg_we  = 1'b0;
    reg_wa  = rs_q;
    case (state_q)
      S_IDLE: begin
        if (rqx) begin
          accept = 1'b1;
          if (opout[15])                  state_d = S_EXEC;
          else if (opout[15:12] == 4'b0001) state_d = S_MREQ;
          else                            state_d = S_NOP;
        end
      end
      S_EXEC: begin
        if (wen_q) begin
          case (dst_q)
            2'b00:   mar_d = alu_r;
            2'b01:   mdr_d = alu_r;
            2'b10:   begin reg_we = 1'b1; reg_wa = rs_q; end
            default: begin reg_we = 1'b1; reg_wa = rd_q; end
          endcase
        end
        state_d = S_IDLE;
      end
      S_MREQ: begin
        if (akm) begin
          if (rdir_q) mdr_d = drm;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Only the micro-op fields the datapath needs are kept after accept.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      dst_q  <= '0;
      wen_q  <= 1'b0;
      rdir_q <= 1'b0;
      aop_q  <= '0;
      rs_q   <= '0;
      rd_q   <= '0;
      imm_q  <= '0;
    end else if (accept) begin
      sel_q  <= opout[13:12];
      dst_q  <= opout[6:5];
      wen_q  <= opout[14];
      rdir_q <= opout[11];
      aop_q  <= opout[11] ? opout[10:7] : aluop;
      rs_q   <= regsrc;
      rd_q   <= regdst;
      imm_q  <= opimm;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[reg_wa] <= alu_r;
    end
  end

  assign byx = (state_q != S_IDLE);
  assign rqm = (state_q == S_MREQ);
  assign rwm = rqm & rdir_q;
  assign dwm = mdr_q;
  assign adm = AW'(mar_q[MW-1:0]);

`ifdef EXEC_FLAGS_EN
  logic [2:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (state_q == S_EXEC && wen_q) flags_d = {alu_r[DW-1], alu_c, (alu_r == '0)};
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;

  logic unused_bits;
  assign unused_bits = ^opout[4:0];
`else
  logic unused_bits;
  assign unused_bits = ^{opout[4:0], alu_c};
`endif

endmodule
